pool_sequencer: RTL and testbench
=================================

POOL_SEQUENCER -- requirements
Module: pool_sequencer

Interface
REQ-001 Parameter MAP_W, default 24: input feature-map width in pixels; even, 2..255.
REQ-002 Parameter MAP_H, default 24: input feature-map height in pixels; even, 2..255.
REQ-003 Parameter DRAIN_MAX, default 16: maximum cycles to wait for outstanding pooled results after the last input pixel.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 n_reset  in  1  reset, synchronous, active-low.
REQ-006 layer_start  in  1  one-cycle request to pool one feature map; honoured only in IDLE.
REQ-007 in_valid  in  1  upstream pixel (all 3 channels) present this cycle.
REQ-008 in_accept  out  1  pixel accepted this cycle; equals in_valid AND state==STREAM.
REQ-009 pe_start  out  1  one-cycle clear pulse to the 3 pooling PEs.
REQ-010 pe_enable  out  1  PE data-valid strobe; equals in_accept.
REQ-011 pool_ready  in  1  pooled result valid from pooling layer (all 3 channels).
REQ-012 out_valid  out  1  pooled result forwarded downstream; equals pool_ready AND state in {STREAM, DRAIN}.
REQ-013 out_row, out_col  out  8 each  pooled-output coordinate of the current out_valid.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on map completion.
REQ-016 err  out  1  sticky error flag; cleared only by reset or an accepted layer_start.

Function
REQ-017 States: IDLE, CLEAR, STREAM, DRAIN, DONE; encoding is free.
REQ-018 IDLE -> CLEAR on layer_start; clears in_row, in_col, out_cnt, out_row, out_col and err.
REQ-019 CLEAR lasts exactly 1 cycle; pe_start=1 only in CLEAR; then -> STREAM.
REQ-020 STREAM: each accepted pixel advances in_col; wrap at MAP_W-1 -> 0 and in_row+1.
REQ-021 STREAM -> DRAIN on the cycle the pixel at (MAP_H-1, MAP_W-1) is accepted; in_accept=0 in DRAIN.
REQ-022 Expected outputs N = (MAP_W/2)*(MAP_H/2); out_cnt increments on each out_valid.
REQ-023 out_col/out_row give the coordinate of the current result: out_col wraps at MAP_W/2-1 and advances out_row; both update on the edge after out_valid.
REQ-024 DRAIN -> DONE when out_cnt reaches N, counting an out_valid in the same cycle.
REQ-025 DRAIN timeout: if the drain cycle counter reaches DRAIN_MAX before out_cnt==N, set err and -> DONE.
REQ-026 pool_ready while out_cnt already ==N, or in IDLE/CLEAR/DONE: set err; out_valid=0; no counter change.
REQ-027 out_cnt reaching N while still in STREAM: set err; state unchanged.
REQ-028 DONE lasts 1 cycle with done=1, then -> IDLE.
REQ-029 layer_start outside IDLE is ignored and has no side effects.
REQ-030 Simultaneous in_accept and out_valid in one cycle: both counters update independently.

Reset
REQ-031 n_reset=0 at a rising edge forces IDLE on that edge, from any state including mid-map.
REQ-032 Reset clears all counters and err; in_accept, pe_start, pe_enable, out_valid, busy and done are 0 during reset and in the following IDLE cycle.

Verification
REQ-033 MAP_W=MAP_H=4, one layer_start, 16 back-to-back pixels, pool_ready 1 cycle after every 4th pixel -> pe_start pulses once; 4 out_valid at (0,0),(0,1),(1,0),(1,1); done once; err=0.
REQ-034 Same config, in_valid toggled randomly -> exactly 16 in_accept; in_accept never high in DRAIN; result as REQ-033.
REQ-035 Final pool_ready withheld -> after DRAIN_MAX=16 cycles: err=1, done pulses, busy=0 next cycle.
REQ-036 Reset asserted after 7 accepted pixels -> IDLE on the next edge; all outputs 0; a new layer_start runs a clean map with err=0.
REQ-037 pool_ready while IDLE, and layer_start while STREAM -> err=1 and out_valid=0 for the first; no state change for the second.
REQ-038 MAP_W=MAP_H=2 -> a single out_valid at (0,0); DONE reached in the same cycle as, or after, that pool_ready.

Source files
------------

// File: rtl/pool_sequencer.sv
// Sequencer for a 2x2 max-pool layer over a 3-channel feature map.
// Ports: clk, n_reset (sync, active-low); layer_start, in_valid, pool_ready in;
//   in_accept, pe_start, pe_enable, out_valid, out_row/out_col[7:0], busy, done, err out.
module pool_sequencer #(
    parameter int MAP_W     = 24,
    parameter int MAP_H     = 24,
    parameter int DRAIN_MAX = 16
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       layer_start,
    input  logic       in_valid,
    output logic       in_accept,
    output logic       pe_start,
    output logic       pe_enable,
    input  logic       pool_ready,
    output logic       out_valid,
    output logic [7:0] out_row,
    output logic [7:0] out_col,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0]  LAST_COL   = 8'(MAP_W - 1);
    localparam logic [7:0]  LAST_ROW   = 8'(MAP_H - 1);
    localparam logic [7:0]  LAST_OCOL  = 8'(MAP_W / 2 - 1);
    localparam logic [15:0] N_OUT      = 16'((MAP_W / 2) * (MAP_H / 2));
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_MAX - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  in_row;
    logic [7:0]  in_row_nx;
    logic [7:0]  in_col;
    logic [7:0]  in_col_nx;
    logic [7:0]  out_row_nx;
    logic [7:0]  out_col_nx;
    logic [15:0] out_cnt;
    logic [15:0] out_cnt_nx;
    logic [15:0] drain_cnt;
    logic [15:0] drain_cnt_nx;
    logic        err_nx;
    logic        flow;
    logic        full;
    logic        accept;
    logic        fwd;
    logic        last_px;
    logic        last_out;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= S_IDLE;
            in_row    <= '0;
            in_col    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_cnt   <= '0;
            drain_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            in_row    <= in_row_nx;
            in_col    <= in_col_nx;
            out_row   <= out_row_nx;
            out_col   <= out_col_nx;
            out_cnt   <= out_cnt_nx;
            drain_cnt <= drain_cnt_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        flow     = (state == S_STREAM) || (state == S_DRAIN);
        full     = (out_cnt == N_OUT);
        accept   = in_valid && (state == S_STREAM);
        fwd      = pool_ready && flow && !full;
        last_px  = (in_row == LAST_ROW) && (in_col == LAST_COL);
        last_out = fwd && ((out_cnt + 16'd1) == N_OUT);

        state_nx     = state;
        in_row_nx    = in_row;
        in_col_nx    = in_col;
        out_row_nx   = out_row;
        out_col_nx   = out_col;
        out_cnt_nx   = out_cnt;
        drain_cnt_nx = drain_cnt;
        err_nx       = err;

        // Input raster and output raster advance independently.
        if (accept) begin
            if (in_col == LAST_COL) begin
                in_col_nx = '0;
                in_row_nx = in_row + 8'd1;
            end else begin
                in_col_nx = in_col + 8'd1;
            end
        end

        if (fwd) begin
            out_cnt_nx = out_cnt + 16'd1;
            if (out_col == LAST_OCOL) begin
                out_col_nx = '0;
                out_row_nx = out_row + 8'd1;
            end else begin
                out_col_nx = out_col + 8'd1;
            end
        end

        unique case (state)
            S_IDLE: begin
                if (layer_start) begin
                    state_nx     = S_CLEAR;
                    in_row_nx    = '0;
                    in_col_nx    = '0;
                    out_row_nx   = '0;
                    out_col_nx   = '0;
                    out_cnt_nx   = '0;
                    drain_cnt_nx = '0;
                    err_nx       = 1'b0;
                end
            end
            S_CLEAR: begin
                state_nx = S_STREAM;
            end
            S_STREAM: begin
                // All results in before the map finished streaming.
                if (last_out) begin
                    err_nx = 1'b1;
                end
                if (accept && last_px) begin
                    state_nx     = S_DRAIN;
                    drain_cnt_nx = '0;
                end
            end
            S_DRAIN: begin
                if (full || last_out) begin
                    state_nx = S_DONE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nx = S_DONE;
                    err_nx   = 1'b1;
                end else begin
                    drain_cnt_nx = drain_cnt + 16'd1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // A result nobody is waiting for is flagged, even on a start cycle.
        if (pool_ready && !fwd) begin
            err_nx = 1'b1;
        end
    end

    // Outputs are forced low while reset is held.
    assign in_accept = accept && n_reset;
    assign pe_enable = accept && n_reset;
    assign pe_start  = (state == S_CLEAR) && n_reset;
    assign out_valid = fwd && n_reset;
    assign busy      = (state != S_IDLE) && n_reset;
    assign done      = (state == S_DONE) && n_reset;

endmodule

// File: tb/tb_pool_sequencer.sv
// Directed bench for pool_sequencer: 4x4 maps on one instance,
// a 2x2 map on a second instance.
module tb_pool_sequencer;

    logic       clk;
    logic       n_reset;
    logic       layer_start;
    logic       in_valid;
    logic       pool_ready;
    logic       in_accept;
    logic       pe_start;
    logic       pe_enable;
    logic       out_valid;
    logic [7:0] out_row;
    logic [7:0] out_col;
    logic       busy;
    logic       done;
    logic       err;

    logic       s_start;
    logic       s_valid;
    logic       s_ready;
    logic       s_accept;
    logic       s_pe_start;
    logic       s_pe_enable;
    logic       s_out_valid;
    logic [7:0] s_row;
    logic [7:0] s_col;
    logic       s_busy;
    logic       s_done;
    logic       s_err;

    int errors = 0;
    int checks = 0;

    pool_sequencer #(.MAP_W(4), .MAP_H(4), .DRAIN_MAX(16)) u_dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .layer_start (layer_start),
        .in_valid    (in_valid),
        .in_accept   (in_accept),
        .pe_start    (pe_start),
        .pe_enable   (pe_enable),
        .pool_ready  (pool_ready),
        .out_valid   (out_valid),
        .out_row     (out_row),
        .out_col     (out_col),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    pool_sequencer #(.MAP_W(2), .MAP_H(2), .DRAIN_MAX(16)) u_small (
        .clk         (clk),
        .n_reset     (n_reset),
        .layer_start (s_start),
        .in_valid    (s_valid),
        .in_accept   (s_accept),
        .pe_start    (s_pe_start),
        .pe_enable   (s_pe_enable),
        .pool_ready  (s_ready),
        .out_valid   (s_out_valid),
        .out_row     (s_row),
        .out_col     (s_col),
        .busy        (s_busy),
        .done        (s_done),
        .err         (s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 4x4 map, back-to-back pixels, a result one cycle after every
    // 4th pixel; the last result is optionally withheld.
    task automatic full_map(input bit final_ready);
        @(negedge clk);
        layer_start = 1'b1;
        in_valid    = 1'b0;
        pool_ready  = 1'b0;
        #1;
        chk("idle_busy", 16'(busy), 16'd0);
        @(negedge clk);
        layer_start = 1'b0;
        #1;
        chk("clr_pe_start", 16'(pe_start), 16'd1);
        chk("clr_err", 16'(err), 16'd0);
        chk("clr_busy", 16'(busy), 16'd1);
        for (int p = 0; p < 16; p++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            pool_ready = (p == 4) || (p == 8) || (p == 12);
            #1;
            chk("px_accept", 16'(in_accept), 16'd1);
            chk("px_enable", 16'(pe_enable), 16'd1);
            chk("px_pe_start", 16'(pe_start), 16'd0);
            chk("px_out_valid", 16'(out_valid), 16'(pool_ready));
            if (pool_ready) begin
                chk("px_row", 16'(out_row), 16'((p / 4 - 1) / 2));
                chk("px_col", 16'(out_col), 16'((p / 4 - 1) % 2));
            end
        end
        @(negedge clk);
        in_valid   = 1'b1;
        pool_ready = final_ready;
        #1;
        chk("drain_accept", 16'(in_accept), 16'd0);
        chk("drain_out_valid", 16'(out_valid), 16'(final_ready));
        if (final_ready) begin
            chk("drain_row", 16'(out_row), 16'd1);
            chk("drain_col", 16'(out_col), 16'd1);
        end
        if (!final_ready) begin
            for (int d = 1; d < 16; d++) begin
                @(negedge clk);
                in_valid   = 1'b0;
                pool_ready = 1'b0;
                #1;
                chk("wait_done", 16'(done), 16'd0);
                chk("wait_busy", 16'(busy), 16'd1);
            end
        end
        @(negedge clk);
        in_valid   = 1'b0;
        pool_ready = 1'b0;
        #1;
        chk("done_pulse", 16'(done), 16'd1);
        chk("done_err", 16'(err), 16'(!final_ready));
        @(negedge clk);
        #1;
        chk("after_busy", 16'(busy), 16'd0);
        chk("after_done", 16'(done), 16'd0);
        chk("after_err", 16'(err), 16'(!final_ready));
    endtask

    initial begin
        int acc;
        int outs;
        int dut_acc;
        int dut_ov;
        bit pend;
        bit seen;
        bit exp_acc;

        n_reset     = 1'b0;
        layer_start = 1'b0;
        in_valid    = 1'b1;
        pool_ready  = 1'b0;
        s_start     = 1'b0;
        s_valid     = 1'b0;
        s_ready     = 1'b0;

        // Reset with in_valid held high.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_accept", 16'(in_accept), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_pe_start", 16'(pe_start), 16'd0);
        @(negedge clk);
        n_reset  = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("idle_accept", 16'(in_accept), 16'd0);
        chk("idle_out_valid", 16'(out_valid), 16'd0);
        chk("idle_row", 16'(out_row), 16'd0);

        // Clean 4x4 map.
        full_map(1'b1);

        // Random in_valid, results follow every 4th accepted pixel.
        @(negedge clk);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        acc     = 0;
        outs    = 0;
        dut_acc = 0;
        dut_ov  = 0;
        pend    = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            in_valid   = 1'($urandom_range(0, 1));
            pool_ready = pend;
            #1;
            exp_acc = in_valid && (acc < 16);
            chk("rnd_accept", 16'(in_accept), 16'(exp_acc));
            dut_acc += int'(in_accept);
            dut_ov  += int'(out_valid);
            if (pend) begin
                chk("rnd_out_valid", 16'(out_valid), 16'd1);
                chk("rnd_row", 16'(out_row), 16'(outs / 2));
                chk("rnd_col", 16'(out_col), 16'(outs % 2));
                outs++;
            end
            pend = exp_acc && ((acc % 4) == 3);
            if (exp_acc) acc++;
            if (done) seen = 1'b1;
        end
        chk("rnd_seen_done", 16'(seen), 16'd1);
        chk("rnd_accept_cnt", 16'(dut_acc), 16'd16);
        chk("rnd_out_cnt", 16'(dut_ov), 16'd4);
        chk("rnd_err", 16'(err), 16'd0);
        @(negedge clk);
        in_valid   = 1'b0;
        pool_ready = 1'b0;
        #1;
        chk("rnd_idle", 16'(busy), 16'd0);

        // Last result withheld: drain timeout.
        full_map(1'b0);

        // New start clears err; layer_start mid-stream is ignored;
        // reset after 7 pixels.
        @(negedge clk);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        #1;
        chk("restart_err", 16'(err), 16'd0);
        for (int p = 0; p < 7; p++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            layer_start = (p == 3);
            #1;
            chk("part_accept", 16'(in_accept), 16'd1);
            chk("part_pe_start", 16'(pe_start), 16'd0);
        end
        @(negedge clk);
        layer_start = 1'b0;
        n_reset     = 1'b0;
        in_valid    = 1'b1;
        pool_ready  = 1'b1;
        #1;
        chk("mid_rst_accept", 16'(in_accept), 16'd0);
        chk("mid_rst_enable", 16'(pe_enable), 16'd0);
        chk("mid_rst_ov", 16'(out_valid), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        n_reset    = 1'b1;
        pool_ready = 1'b0;
        #1;
        chk("post_rst_busy", 16'(busy), 16'd0);
        chk("post_rst_accept", 16'(in_accept), 16'd0);
        chk("post_rst_done", 16'(done), 16'd0);
        chk("post_rst_err", 16'(err), 16'd0);
        full_map(1'b1);

        // Stray result while idle.
        @(negedge clk);
        pool_ready = 1'b1;
        #1;
        chk("stray_ov", 16'(out_valid), 16'd0);
        @(negedge clk);
        pool_ready = 1'b0;
        #1;
        chk("stray_err", 16'(err), 16'd1);
        chk("stray_busy", 16'(busy), 16'd0);

        // 2x2 map: a single result at (0,0).
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        #1;
        chk("s_pe_start", 16'(s_pe_start), 16'd1);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            s_valid = 1'b1;
            #1;
            chk("s_accept", 16'(s_accept), 16'd1);
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_ready = 1'b1;
        #1;
        chk("s_drain_accept", 16'(s_accept), 16'd0);
        chk("s_out_valid", 16'(s_out_valid), 16'd1);
        chk("s_row", 16'(s_row), 16'd0);
        chk("s_col", 16'(s_col), 16'd0);
        @(negedge clk);
        s_valid = 1'b0;
        s_ready = 1'b0;
        #1;
        chk("s_done", 16'(s_done), 16'd1);
        chk("s_err", 16'(s_err), 16'd0);
        @(negedge clk);
        #1;
        chk("s_idle", 16'(s_busy), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
